// File: rtl/fifo_rd_scheduler_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_scheduler_if
// Purpose : bundles the FIFO read-port, SPI byte path and status signals that
//           connect fifo_rd_scheduler to the FIFO, count_prebufer, main_ctrl
//           and SPI_slave.
// Modports: master - the scheduler (drives fifo_rd_en, byte path, status)
//           slave  - the environment (FIFO flags/data, SPI and control pulses)
// Signals : fifo_q[23:0], fifo_empty, fifo_full, fifo_wr_en   FIFO side
//           byte_req, xfer_done, flush                          request pulses
//           fifo_rd_en, byte_out[7:0], byte_valid, underflow    read/byte path
//           fifo_level[3:0], overflow_cnt[7:0], busy            status
// ---------------------------------------------------------------------------
interface fifo_rd_scheduler_if;
    logic [23:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic        byte_req;
    logic        xfer_done;
    logic        flush;
    logic        fifo_rd_en;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        underflow;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;
    logic        busy;

    modport master (
        input  fifo_q, fifo_empty, fifo_full, fifo_wr_en,
        input  byte_req, xfer_done, flush,
        output fifo_rd_en, byte_out, byte_valid, underflow,
        output fifo_level, overflow_cnt, busy
    );

    modport slave (
        output fifo_q, fifo_empty, fifo_full, fifo_wr_en,
        output byte_req, xfer_done, flush,
        input  fifo_rd_en, byte_out, byte_valid, underflow,
        input  fifo_level, overflow_cnt, busy
    );
endinterface

// File: rtl/fifo_rd_scheduler.sv
// ---------------------------------------------------------------------------
// fifo_rd_scheduler
// Purpose : owns the read port of the 24-bit measurement FIFO and shares it
//           between the SPI byte readout (one word served as 3 bytes, LSB
//           first) and the overflow discard (drops the oldest word when a
//           write hits a full FIFO). Also tracks the word level and the
//           saturating dropped-word count.
// Ports   : clk_12mhz  system clock
//           rst_sync   asynchronous, active-high reset
//           bus        fifo_rd_scheduler_if.master (see interface header)
// ---------------------------------------------------------------------------
module fifo_rd_scheduler #(
    parameter int          DEPTH      = 8,
    parameter int          RD_LATENCY = 2,      // 1..3
    parameter logic [7:0]  EMPTY_BYTE = 8'hFF
) (
    input  logic                  clk_12mhz,
    input  logic                  rst_sync,
    fifo_rd_scheduler_if.master   bus
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_e;

    localparam logic [1:0] LAT_INIT  = 2'(RD_LATENCY);
    localparam logic [3:0] LEVEL_MAX = 4'(DEPTH);

    state_e      state_q;
    logic [1:0]  lat_cnt_q;
    logic [23:0] word_q;
    logic [1:0]  byte_idx_q;
    logic        pending_q;
    logic        discard_q;
    logic        rd_en_q;
    logic [7:0]  byte_out_q;
    logic        byte_valid_q;
    logic        underflow_q;
    logic        busy_q;
    logic [3:0]  level_q, level_d;
    logic [7:0]  ovf_q, ovf_d;

    logic        req_eff;
    logic        full_write;
    logic        drop_done;
    logic        reject;
    logic        lvl_inc;
    logic        lvl_dec;
    logic [8:0]  ovf_sum;

    // A request that arrived while the port was busy is replayed in IDLE.
    assign req_eff    = bus.byte_req || pending_q;
    assign full_write = bus.fifo_wr_en && bus.fifo_full;
    assign drop_done  = (state_q == DROP) && (lat_cnt_q == 2'd0);
    // Full-writes outside IDLE cannot start a drop; the FIFO just loses them.
    assign reject     = full_write && (state_q != IDLE);
    assign lvl_inc    = bus.fifo_wr_en && !bus.fifo_full;
    assign lvl_dec    = rd_en_q && (level_q != 4'd0);

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = 4'd0;
        end else if (bus.fifo_empty && !bus.fifo_wr_en) begin
            level_d = 4'd0;
        end else if (lvl_inc && !lvl_dec && (level_q < LEVEL_MAX)) begin
            level_d = level_q + 4'd1;
        end else if (lvl_dec && !lvl_inc) begin
            level_d = level_q - 4'd1;
        end
    end

    always_comb begin
        ovf_sum = {1'b0, ovf_q} + 9'(drop_done) + 9'(reject);
        ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        if (bus.flush) begin
            ovf_d = 8'd0;
        end
    end

    // NOTE: all state uses non-blocking assignments; pulse outputs default low each cycle.
    always_ff @(posedge clk_12mhz or posedge rst_sync) begin
        if (rst_sync) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 2'd0;
            word_q       <= 24'd0;
            byte_idx_q   <= 2'd0;
            pending_q    <= 1'b0;
            discard_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            byte_out_q   <= EMPTY_BYTE;
            byte_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            busy_q       <= 1'b0;
            level_q      <= 4'd0;
            ovf_q        <= 8'd0;
        end else begin
            rd_en_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            level_q      <= level_d;
            ovf_q        <= ovf_d;

            if (bus.flush) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                byte_idx_q <= 2'd0;
                pending_q  <= 1'b0;
                discard_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (req_eff) begin
                            pending_q <= 1'b0;
                            if (bus.fifo_empty) begin
                                byte_out_q   <= EMPTY_BYTE;
                                byte_valid_q <= 1'b1;
                                underflow_q  <= 1'b1;
                            end else begin
                                // SPI fetch beats a simultaneous full-write: it frees a slot anyway.
                                rd_en_q   <= 1'b1;
                                lat_cnt_q <= LAT_INIT;
                                discard_q <= 1'b0;
                                state_q   <= FETCH;
                                busy_q    <= 1'b1;
                            end
                        end else if (full_write) begin
                            rd_en_q   <= 1'b1;
                            lat_cnt_q <= LAT_INIT;
                            state_q   <= DROP;
                            busy_q    <= 1'b1;
                        end
                    end

                    FETCH: begin
                        if (bus.byte_req) pending_q <= 1'b1;
                        if (bus.xfer_done) begin
                            discard_q <= 1'b1;
                            pending_q <= 1'b0;
                        end
                        if (lat_cnt_q == 2'd0) begin
                            // Word was latched last cycle; announce byte 0 unless the frame ended.
                            if (!discard_q && !bus.xfer_done) begin
                                byte_valid_q <= 1'b1;
                                byte_idx_q   <= 2'd1;
                                state_q      <= HOLD;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            lat_cnt_q <= lat_cnt_q - 2'd1;
                            if (lat_cnt_q == 2'd1) begin
                                word_q <= bus.fifo_q;
                                if (!discard_q && !bus.xfer_done) begin
                                    byte_out_q <= bus.fifo_q[7:0];
                                end
                            end
                        end
                    end

                    HOLD: begin
                        if (bus.xfer_done) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            byte_idx_q <= 2'd0;
                            pending_q  <= 1'b0;
                        end else if (bus.byte_req) begin
                            byte_out_q   <= word_q[{byte_idx_q, 3'b000} +: 8];
                            byte_valid_q <= 1'b1;
                            if (byte_idx_q == 2'd2) begin
                                state_q    <= IDLE;
                                busy_q     <= 1'b0;
                                byte_idx_q <= 2'd0;
                            end else begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                    end

                    DROP: begin
                        if (bus.byte_req)  pending_q <= 1'b1;
                        if (bus.xfer_done) pending_q <= 1'b0;
                        if (lat_cnt_q == 2'd0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            lat_cnt_q <= lat_cnt_q - 2'd1;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_rd_en   = rd_en_q;
    assign bus.byte_out     = byte_out_q;
    assign bus.byte_valid   = byte_valid_q;
    assign bus.underflow    = underflow_q;
    assign bus.fifo_level   = level_q;
    assign bus.overflow_cnt = ovf_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_scheduler
// Directed bench for fifo_rd_scheduler. A small behavioural FIFO (registered
// read data, rejects writes when full, cleared by flush) stands in for the
// real FIFO; a write that triggers a drop is retried by the bench, as the
// prebuffer would. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_rd_scheduler;
    localparam int DEPTH      = 8;
    localparam int RD_LATENCY = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rd_scheduler_if bus();

    fifo_rd_scheduler #(
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .EMPTY_BYTE (8'hFF)
    ) dut (
        .clk_12mhz (clk),
        .rst_sync  (rst),
        .bus       (bus)
    );

    // ---------------- FIFO model ----------------
    logic [23:0] mq[$];
    int          mcount    = 0;
    logic [23:0] fifo_q_r  = 24'd0;
    logic [23:0] wr_data;

    assign bus.fifo_q     = fifo_q_r;
    assign bus.fifo_empty = (mcount == 0);
    assign bus.fifo_full  = (mcount == DEPTH);

    always @(posedge clk) begin
        logic [23:0] popped;
        bit          was_full;
        was_full = (mq.size() == DEPTH);
        if (bus.flush) begin
            mq.delete();
        end else begin
            if (bus.fifo_rd_en && mq.size() != 0) begin
                popped = mq.pop_front();
                fifo_q_r <= popped;
            end
            if (bus.fifo_wr_en && !was_full) mq.push_back(wr_data);
        end
        mcount <= mq.size();
    end

    // ---------------- event monitor ----------------
    int   rd_cnt = 0, vld_cnt = 0, uf_cnt = 0, rule_bad = 0;
    logic prev_rd = 1'b0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            if (bus.fifo_empty || prev_rd) rule_bad++;
        end
        prev_rd = bus.fifo_rd_en;
        if (bus.byte_valid) vld_cnt++;
        if (bus.underflow)  uf_cnt++;
    end

    // ---------------- helpers ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [23:0] d);
        wr_data        = d;
        bus.fifo_wr_en = 1'b1;
        step();
        bus.fifo_wr_en = 1'b0;
    endtask

    task automatic pulse_req();
        bus.byte_req = 1'b1;
        step();
        bus.byte_req = 1'b0;
    endtask

    task automatic pulse_xfer_done();
        bus.xfer_done = 1'b1;
        step();
        bus.xfer_done = 1'b0;
    endtask

    // Cycles from raising byte_req to seeing byte_valid; 0 if it never comes.
    task automatic fetch_latency(output int lat);
        lat = 0;
        bus.byte_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) bus.byte_req = 1'b0;
            if (bus.byte_valid) begin
                lat = i;
                break;
            end
        end
        bus.byte_req = 1'b0;
    endtask

    task automatic wait_idle(output int ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, ok, rd0, v0;
        logic [7:0] b;

        rst            = 1'b1;
        bus.byte_req   = 1'b0;
        bus.xfer_done  = 1'b0;
        bus.flush      = 1'b0;
        bus.fifo_wr_en = 1'b0;
        wr_data        = 24'd0;
        step(2);
        rst = 1'b0;
        step();

        // Reset state
        check("rst_byte_out", 32'(bus.byte_out), 32'hFF);
        check("rst_rd_en",    32'(bus.fifo_rd_en), 0);
        check("rst_valid",    32'(bus.byte_valid), 0);
        check("rst_level",    32'(bus.fifo_level), 0);
        check("rst_ovf",      32'(bus.overflow_cnt), 0);
        check("rst_busy",     32'(bus.busy), 0);

        // 1. One word read out as three bytes, LSB first
        write_word(24'h563412);
        check("t1_level1", 32'(bus.fifo_level), 1);
        fetch_latency(lat);
        check("t1_latency", lat, 4);
        check("t1_byte0",   32'(bus.byte_out), 32'h12);
        check("t1_level0",  32'(bus.fifo_level), 0);
        step(9);
        pulse_req();
        check("t1_valid1", 32'(bus.byte_valid), 1);
        check("t1_byte1",  32'(bus.byte_out), 32'h34);
        step(9);
        pulse_req();
        check("t1_valid2", 32'(bus.byte_valid), 1);
        check("t1_byte2",  32'(bus.byte_out), 32'h56);
        check("t1_idle",   32'(bus.busy), 0);
        check("t1_rd_cnt", rd_cnt, 1);

        // 2. Request on an empty FIFO
        rd0 = rd_cnt;
        pulse_req();
        check("t2_valid",     32'(bus.byte_valid), 1);
        check("t2_underflow", 32'(bus.underflow), 1);
        check("t2_byte",      32'(bus.byte_out), 32'hFF);
        step(3);
        check("t2_no_rd",  rd_cnt, rd0);
        check("t2_level",  32'(bus.fifo_level), 0);
        check("t2_uf_cnt", uf_cnt, 1);

        // 3. Fill, then three writes while full; each drops the oldest word
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(i);
            write_word({8'hC0 | b, 8'hB0 | b, 8'hA0 | b});
        end
        check("t3_level_full", 32'(bus.fifo_level), 8);
        rd0 = rd_cnt;
        for (int k = 0; k < 3; k++) begin
            wr_data        = 24'hEEEE00 + 24'(k);
            bus.fifo_wr_en = 1'b1;
            step();
            bus.fifo_wr_en = 1'b0;
            check("t3_drop_busy", 32'(bus.busy), 1);
            wait_idle(ok);
            check("t3_drop_done", ok, 1);
            write_word(24'hD0D0D0 + 24'(k));
        end
        check("t3_ovf",    32'(bus.overflow_cnt), 3);
        check("t3_level",  32'(bus.fifo_level), 8);
        check("t3_rd_cnt", rd_cnt, rd0 + 3);
        fetch_latency(lat);
        check("t3_oldest_gone", 32'(bus.byte_out), 32'hA3);
        pulse_xfer_done();
        check("t3_xfer_idle", 32'(bus.busy), 0);
        check("t3_level7",    32'(bus.fifo_level), 7);

        // 4. Full FIFO: byte_req and full-write together -> fetch wins
        write_word(24'h777777);
        check("t4_full", 32'(bus.fifo_level), 8);
        rd0 = rd_cnt;
        wr_data        = 24'h999999;
        bus.byte_req   = 1'b1;
        bus.fifo_wr_en = 1'b1;
        step();
        bus.byte_req   = 1'b0;
        bus.fifo_wr_en = 1'b0;
        step(3);
        check("t4_valid",  32'(bus.byte_valid), 1);
        check("t4_byte",   32'(bus.byte_out), 32'hA4);
        check("t4_one_rd", rd_cnt, rd0 + 1);
        check("t4_ovf",    32'(bus.overflow_cnt), 3);
        check("t4_level",  32'(bus.fifo_level), 7);

        // 5. xfer_done after one byte, then a fresh word is fetched
        pulse_xfer_done();
        check("t5_idle", 32'(bus.busy), 0);
        fetch_latency(lat);
        check("t5_latency", lat, 4);
        check("t5_byte",    32'(bus.byte_out), 32'hA5);
        check("t5_level",   32'(bus.fifo_level), 6);
        pulse_xfer_done();

        // 6. flush in the middle of FETCH
        v0 = vld_cnt;
        bus.byte_req = 1'b1;
        step();
        bus.byte_req = 1'b0;
        check("t6_fetch_busy", 32'(bus.busy), 1);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("t6_idle",  32'(bus.busy), 0);
        check("t6_level", 32'(bus.fifo_level), 0);
        check("t6_ovf",   32'(bus.overflow_cnt), 0);
        step(5);
        check("t6_no_valid", vld_cnt, v0);

        // 7. Asynchronous reset mid-FETCH drops the word in flight
        write_word(24'hABCDEF);
        bus.byte_req = 1'b1;
        step();
        bus.byte_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("t7_byte_out", 32'(bus.byte_out), 32'hFF);
        check("t7_busy",     32'(bus.busy), 0);
        check("t7_level",    32'(bus.fifo_level), 0);
        step();
        rst = 1'b0;
        step(5);
        check("t7_no_valid", vld_cnt, v0);

        // rd_en never while empty, never two cycles in a row
        check("rd_en_rules", rule_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
